// File: rtl/seq_pkg.sv
// Shared ctrl/state encodings and debounce defaults for the input_sequencer front-end.
package seq_pkg;

    localparam logic [1:0] CTRL_OP   = 2'b00;
    localparam logic [1:0] CTRL_SRC0 = 2'b01;
    localparam logic [1:0] CTRL_SRC1 = 2'b10;
    localparam logic [1:0] CTRL_EXEC = 2'b11;

    // 10 ms at 100 MHz; CNT_W_DEFAULT must keep 2**CNT_W above this.
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int CNT_W_DEFAULT      = 20;

    typedef enum logic [1:0] {
        S_OP   = CTRL_OP,
        S_SRC0 = CTRL_SRC0,
        S_SRC1 = CTRL_SRC1,
        S_EXEC = CTRL_EXEC
    } state_t;

    function automatic state_t next_state(input state_t s);
        case (s)
            S_OP:    return S_SRC0;
            S_SRC0:  return S_SRC1;
            S_SRC1:  return S_EXEC;
            S_EXEC:  return S_OP;
            default: return S_OP;
        endcase
    endfunction

endpackage

// File: rtl/input_sequencer_if.sv
// Button/switch inputs and register-bank strobe outputs of the input_sequencer.
interface input_sequencer_if;

    logic       btn;
    logic [4:0] sw;
    logic [1:0] ctrl_sw;
    logic       enable;
    logic [4:0] in_data;
    logic [1:0] ctrl;
    logic [1:0] step;

    // master drives the raw board inputs and consumes the strobe
    modport master (
        output btn, sw, ctrl_sw,
        input  enable, in_data, ctrl, step
    );

    modport slave (
        input  btn, sw, ctrl_sw,
        output enable, in_data, ctrl, step
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser, debounce counter and rising-edge detector; press is one cycle wide.
module btn_debounce
    import seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(DEB_CYCLES)) begin : g_bad_param
        $error("btn_debounce: DEB_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: all state uses non-blocking assignments so s1 -> s2 is a true two-stage pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/input_sequencer.sv
// Button-driven strobe generator for the ALU lab register bank.
// Define INPUT_SEQ_AUTO_STEP_EN to compile in the op/src0/src1/exec auto-step FSM.
module input_sequencer
    import seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input_sequencer_if.slave   bus
);

    logic       press;
    logic [1:0] code;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .press (press)
    );

`ifdef INPUT_SEQ_AUTO_STEP_EN
    state_t state;
    logic   unused_ctrl_sw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OP;
        end else if (press) begin
            state <= next_state(state);
        end
    end

    // The code issued is the state before the advance, so the sequence starts at op.
    assign code           = state;
    assign bus.step       = state;
    assign unused_ctrl_sw = ^bus.ctrl_sw;
`else
    assign code     = bus.ctrl_sw;
    assign bus.step = bus.ctrl_sw;
`endif

    // enable, in_data and ctrl share one edge so the bank sees them coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.enable  <= 1'b0;
            bus.in_data <= '0;
            bus.ctrl    <= CTRL_OP;
        end else begin
            bus.enable <= press;
            if (press) begin
                bus.in_data <= bus.sw;
                bus.ctrl    <= code;
            end
        end
    end

endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench for input_sequencer (DEB_CYCLES=4); follows INPUT_SEQ_AUTO_STEP_EN if defined.
module tb_input_sequencer;
    import seq_pkg::*;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    input_sequencer_if bus ();

    input_sequencer #(
        .DEB_CYCLES (DEB),
        .CNT_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    int         strobes = 0;
    logic [4:0] last_data;
    logic [1:0] last_ctrl;

    // Reference model: a level is accepted once the button, seen through two
    // flops, has held the opposite value for DEB consecutive samples.
    logic [15:0] hist;
    logic        stable_m;
    logic        pend_press;
    logic        flip;
    int          press_count;
    logic        exp_enable;
    logic [4:0]  exp_in_data;
    logic [1:0]  exp_ctrl;
    logic [1:0]  exp_step;

    always @(posedge clk) begin
        if (rst) begin
            hist        = '0;
            stable_m    = 1'b0;
            pend_press  = 1'b0;
            press_count = 0;
            exp_enable  = 1'b0;
            exp_in_data = '0;
            exp_ctrl    = CTRL_OP;
        end else begin
            exp_enable = pend_press;
            if (pend_press) begin
                exp_in_data = bus.sw;
`ifdef INPUT_SEQ_AUTO_STEP_EN
                exp_ctrl = 2'(press_count % 4);
`else
                exp_ctrl = bus.ctrl_sw;
`endif
                press_count++;
            end
            hist = {hist[14:0], bus.btn};
            flip = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (hist[j] == stable_m) flip = 1'b0;
            pend_press = 1'b0;
            if (flip) begin
                stable_m   = ~stable_m;
                pend_press = stable_m;
            end
        end
    end

`ifdef INPUT_SEQ_AUTO_STEP_EN
    assign exp_step = 2'(press_count % 4);
`else
    assign exp_step = bus.ctrl_sw;
`endif

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (bus.enable !== exp_enable) begin
                miscompares++;
                $display("FAIL enable @%0t: got %b want %b", $time, bus.enable, exp_enable);
            end
            vectors++;
            if (bus.in_data !== exp_in_data) begin
                miscompares++;
                $display("FAIL in_data @%0t: got %h want %h", $time, bus.in_data, exp_in_data);
            end
            vectors++;
            if (bus.ctrl !== exp_ctrl) begin
                miscompares++;
                $display("FAIL ctrl @%0t: got %b want %b", $time, bus.ctrl, exp_ctrl);
            end
            vectors++;
            if (bus.step !== exp_step) begin
                miscompares++;
                $display("FAIL step @%0t: got %b want %b", $time, bus.step, exp_step);
            end
            if (bus.enable === 1'b1) begin
                strobes++;
                last_data = bus.in_data;
                last_ctrl = bus.ctrl;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic press_release(input logic [4:0] d, input logic [1:0] c);
        bus.sw      = d;
        bus.ctrl_sw = c;
        bus.btn     = 1'b1;
        tick(10);
        bus.btn = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        tick(3);
        mon_en = 1'b1;
        vectors++;
        if ({bus.enable, bus.in_data, bus.ctrl, bus.step} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_values: got en=%b data=%h ctrl=%b step=%b want all zero",
                     bus.enable, bus.in_data, bus.ctrl, bus.step);
        end
    endtask

    task automatic test_latency();
        rst         = 1'b0;
        bus.btn     = 1'b1;
        bus.sw      = 5'h13;
        bus.ctrl_sw = 2'b00;
        for (int e = 0; e <= 12; e++) begin
            tick(1);
            vectors++;
            if (bus.enable !== (e == 6)) begin
                miscompares++;
                $display("FAIL latency_enable after edge %0d: got %b want %b", e, bus.enable, e == 6);
            end
            if (e == 6) begin
                vectors++;
                if (bus.in_data !== 5'h13 || bus.ctrl !== CTRL_OP) begin
                    miscompares++;
                    $display("FAIL latency_data: got data=%h ctrl=%b want 13/00", bus.in_data, bus.ctrl);
                end
`ifdef INPUT_SEQ_AUTO_STEP_EN
                vectors++;
                if (bus.step !== CTRL_SRC0) begin
                    miscompares++;
                    $display("FAIL latency_step: got %b want 01", bus.step);
                end
`endif
            end
        end
        bus.btn = 1'b0;
        tick(12);
    endtask

    task automatic test_sequence();
        logic [4:0] vals [4] = '{5'h01, 5'h02, 5'h1F, 5'h00};
        logic [1:0] csw;
        logic [1:0] want;
        int         s0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            s0  = strobes;
            csw = 2'($urandom);
`ifdef INPUT_SEQ_AUTO_STEP_EN
            want = 2'(i);
`else
            want = csw;
`endif
            press_release(vals[i], csw);
            vectors++;
            if (strobes != s0 + 1 || last_data !== vals[i] || last_ctrl !== want) begin
                miscompares++;
                $display("FAIL sequence press %0d: got n=%0d data=%h ctrl=%b want n=1 data=%h ctrl=%b",
                         i, strobes - s0, last_data, last_ctrl, vals[i], want);
            end
        end
`ifdef INPUT_SEQ_AUTO_STEP_EN
        vectors++;
        if (bus.step !== CTRL_OP) begin
            miscompares++;
            $display("FAIL sequence_wrap: got step=%b want 00", bus.step);
        end
`endif
    endtask

    task automatic test_bounce();
        int s0 = strobes;
        repeat (10) begin
            bus.btn = 1'b1;
            tick(3);
            bus.btn = 1'b0;
            tick(2);
        end
        tick(10);
        vectors++;
        if (strobes != s0) begin
            miscompares++;
            $display("FAIL bounce: got %0d strobes want 0", strobes - s0);
        end
    endtask

    task automatic test_hold();
        int s0 = strobes;
        bus.sw  = 5'($urandom);
        bus.btn = 1'b1;
        tick(100);
        vectors++;
        if (strobes != s0 + 1) begin
            miscompares++;
            $display("FAIL hold_single: got %0d strobes want 1", strobes - s0);
        end
        bus.btn = 1'b0;
        tick(3);
        bus.btn = 1'b1;
        tick(20);
        vectors++;
        if (strobes != s0 + 1) begin
            miscompares++;
            $display("FAIL hold_short_release: got %0d strobes want 1", strobes - s0);
        end
        bus.btn = 1'b0;
        tick(8);
        bus.btn = 1'b1;
        tick(10);
        vectors++;
        if (strobes != s0 + 2) begin
            miscompares++;
            $display("FAIL hold_second_press: got %0d strobes want 2", strobes - s0);
        end
        bus.btn = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        int         s0;
        logic [1:0] want;
        apply_reset();
        press_release(5'h0A, 2'b01);
        press_release(5'h15, 2'b10);
        bus.ctrl_sw = 2'b11;
        bus.btn     = 1'b1;
        tick(3);
        s0  = strobes;
        rst = 1'b1;
        tick(1);
        vectors++;
        if (bus.enable !== 1'b0 || bus.in_data !== 5'h00 || bus.ctrl !== CTRL_OP) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got en=%b data=%h ctrl=%b want 0/00/00",
                     bus.enable, bus.in_data, bus.ctrl);
        end
`ifdef INPUT_SEQ_AUTO_STEP_EN
        want = CTRL_OP;
        vectors++;
        if (bus.step !== CTRL_OP) begin
            miscompares++;
            $display("FAIL reset_mid_step: got %b want 00", bus.step);
        end
`else
        want = 2'b11;
`endif
        rst = 1'b0;
        tick(12);
        vectors++;
        if (strobes != s0 + 1 || last_ctrl !== want) begin
            miscompares++;
            $display("FAIL reset_mid_repress: got n=%0d ctrl=%b want n=1 ctrl=%b",
                     strobes - s0, last_ctrl, want);
        end
        bus.btn = 1'b0;
        tick(10);
    endtask

    task automatic test_manual();
        logic [1:0] v;
`ifndef INPUT_SEQ_AUTO_STEP_EN
        press_release(5'h1E, 2'b10);
        vectors++;
        if (last_ctrl !== 2'b10 || last_data !== 5'h1E) begin
            miscompares++;
            $display("FAIL manual_capture: got ctrl=%b data=%h want 10/1E", last_ctrl, last_data);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            v           = 2'($urandom);
            bus.ctrl_sw = v;
            #1;
            vectors++;
            if (bus.step !== exp_step) begin
                miscompares++;
                $display("FAIL step_track ctrl_sw=%b: got %b want %b", v, bus.step, exp_step);
            end
            tick(1);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 80; seg++) begin
            bus.btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.sw = 5'($urandom);
            bus.ctrl_sw = 2'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick($urandom_range(1, 10));
        end
        bus.btn = 1'b0;
        tick(12);
    endtask

    initial begin
        bus.btn     = 1'b0;
        bus.sw      = '0;
        bus.ctrl_sw = '0;
        test_reset();
        test_latency();
        test_sequence();
        test_bounce();
        test_hold();
        test_reset_mid();
        test_manual();
        test_random();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
